edge_event_scheduler: RTL
=========================

# edge_event_scheduler

Collects one-cycle pulses from up to NCH edge-detector channels, counts pending events per channel and hands them to a single shared downstream consumer over a valid/ready channel. Channels are served round-robin, so no detector can starve another. The block sits between the bank of edge detectors and the event-processing logic, and also provides per-channel enable and overflow reporting.

## Interface
Parameters:
- NCH, 4, number of detector channels (2..8)
- CW, 2, channel-index width; must equal clog2(NCH)
- PW, 3, width of each per-channel pending counter

Ports:
- clk  in  1  clock; all state changes on posedge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- pulse  in  NCH  per-channel one-cycle event pulses from the edge detectors
- ch_en  in  NCH  per-channel enable; a pulse on a disabled channel is ignored
- ev_valid  out  1  an event record is offered; reset value 0
- ev_ready  in  1  consumer accepts the record
- ev_ch  out  CW  channel index of the offered record; reset value 0
- ev_count  out  PW  number of events merged into the record (1..2^PW-1); reset value 0
- ovf  out  NCH  sticky per-channel overflow flag; reset value 0
- ovf_clr  in  NCH  per-channel overflow clear, one cycle

## Operation
- pend[i] (PW bits) increments when pulse[i] && ch_en[i].
  - Saturates at 2^PW-1.
  - A pulse arriving while pend[i] is saturated sets ovf[i].
- ovf[i] clears on ovf_clr[i]. If a set and a clear coincide, set wins.
- Clearing ch_en[i] does not flush pend[i]. Existing events are still drained.
- FSM states:
  - IDLE: if any pend[i] != 0, pick the first nonzero channel searching upward from (last+1) mod NCH, with wrap.
    - Load ev_ch = i and ev_count = pend[i].
    - Clear pend[i], go to OFFER.
    - If pulse[i] is qualified in the same cycle, pend[i] becomes 1, not 0.
  - OFFER: ev_valid = 1. ev_ch and ev_count are held stable until ev_ready.
    - On ev_valid && ev_ready: last = ev_ch, go to IDLE.
    - Pulses on any channel, including ev_ch, keep accumulating in pend during OFFER.
- last resets to NCH-1, so channel 0 has first priority after reset.
- ev_valid never drops without a handshake.
- Asserting reset mid-OFFER aborts the record. The event is lost and ev_valid drops asynchronously.
- ev_ready while in IDLE is ignored.

## Timing
- Pulse sampled at edge t → pend updated after edge t → grant at edge t+1 → ev_valid high after edge t+1 (1-cycle latency from the sampling edge, block idle).
- Peak throughput: one record per 2 cycles (IDLE/OFFER alternate). Events arriving faster are merged through ev_count.
- ovf[i] rises the cycle after the saturating pulse is sampled.
- All outputs are registered. No combinational path exists from any input to any output.

## Structure
- Package edge_sched_pkg holds:
  - state enum {S_IDLE, S_OFFER}
  - PW_MAX constant
  - the clog2 helper function
- Sub-module edge_rr_pick: a purely combinational round-robin picker.
  - Inputs: request vector (pend != 0), last index.
  - Outputs: hit flag, chosen index.
- The top holds the pend counters, ovf flags, FSM and output registers.

## Test plan
- Reset released, single pulse on ch2 at edge 5 → ev_valid=1, ev_ch=2, ev_count=1 after edge 6. With ev_ready=1, ev_valid=0 after edge 7.
- Pulses on ch0, ch1 and ch3 in the same cycle, ev_ready held 1 → records in order ch0, ch1, ch3, each with ev_count=1. Next grant after a new ch0 pulse goes to ch0 only after ch1/ch3 have been served.
- ev_ready=0 for 20 cycles while ch1 pulses 10 times (PW=3) → first record stays stable. pend[1] saturates at 7 and ovf[1]=1. Next ch1 record has ev_count=7. ovf_clr[1] then clears ovf[1].
- ch_en[3]=0, pulse[3] toggling → no ch3 records. Set pulse in same cycle as grant clear of ch0 → pend[0]=1 and a second ch0 record follows.
- Reset driven low during OFFER → ev_valid, ev_ch, ev_count, ovf all 0 immediately. After release, first grant favours ch0.
- ovf_clr[2] coincident with a saturating pulse on ch2 → ovf[2] stays 1.

Source files
------------

// File: rtl/edge_sched_pkg.sv
// Shared types and helpers for the edge event scheduler.
// Holds the FSM state encoding, the counter-width limit and a constant clog2.
package edge_sched_pkg;

  typedef enum logic {
    S_IDLE,
    S_OFFER
  } state_t;

  // Widest pending counter the scheduler is meant to be built with.
  localparam int unsigned PW_MAX = 8;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/edge_rr_pick.sv
// Combinational round-robin picker: first requesting channel searching
// upward from (i_last+1) mod NCH, wrapping around.
module edge_rr_pick
  import edge_sched_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = clog2(NCH)
) (
  input  logic [NCH-1:0] i_req,
  input  logic [CW-1:0]  i_last,
  output logic           o_hit,
  output logic [CW-1:0]  o_idx
);

  always_comb begin : p_pick
    int unsigned c;
    o_hit = 1'b0;
    o_idx = '0;
    c     = 0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      c = (32'(i_last) + k) % NCH;
      if (!o_hit && i_req[c[CW-1:0]]) begin
        o_hit = 1'b1;
        o_idx = c[CW-1:0];
      end
    end
  end

endmodule

// File: rtl/edge_event_scheduler.sv
// Merges per-channel edge pulses into pending counts and serves them
// round-robin as records on a single valid/ready channel.
module edge_event_scheduler
  import edge_sched_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 2,
  parameter int unsigned PW  = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] pulse,
  input  logic [NCH-1:0] ch_en,
  output logic           ev_valid,
  input  logic           ev_ready,
  output logic [CW-1:0]  ev_ch,
  output logic [PW-1:0]  ev_count,
  output logic [NCH-1:0] ovf,
  input  logic [NCH-1:0] ovf_clr
);

  logic [PW-1:0]  r_pend [NCH];
  logic [NCH-1:0] r_ovf;
  state_t         r_state;
  logic [CW-1:0]  r_last;
  logic           r_ev_valid;
  logic [CW-1:0]  r_ev_ch;
  logic [PW-1:0]  r_ev_count;

  logic [NCH-1:0] w_req;
  logic [NCH-1:0] w_inc;
  logic [NCH-1:0] w_take;
  logic           w_hit;
  logic [CW-1:0]  w_idx;

  always_comb begin
    w_req  = '0;
    w_inc  = '0;
    w_take = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      w_req[i]  = (r_pend[i] != '0);
      w_inc[i]  = pulse[i] & ch_en[i];
      w_take[i] = (r_state == S_IDLE) && w_hit && (w_idx == CW'(i));
    end
  end

  edge_rr_pick #(
    .NCH (NCH),
    .CW  (CW)
  ) u_pick (
    .i_req  (w_req),
    .i_last (r_last),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );

  // A pulse coinciding with the grant restarts the counter at 1, so nothing
  // is dropped there and the overflow flag is left alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        r_pend[i] <= '0;
      end
      r_ovf <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (w_take[i]) begin
          r_pend[i] <= PW'(w_inc[i]);
        end else if (w_inc[i] && (r_pend[i] != '1)) begin
          r_pend[i] <= r_pend[i] + PW'(1);
        end

        if (w_inc[i] && !w_take[i] && (r_pend[i] == '1)) begin
          r_ovf[i] <= 1'b1;
        end else if (ovf_clr[i]) begin
          r_ovf[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_last     <= CW'(NCH - 1);
      r_ev_valid <= 1'b0;
      r_ev_ch    <= '0;
      r_ev_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_ev_ch    <= w_idx;
            r_ev_count <= r_pend[w_idx];
            r_ev_valid <= 1'b1;
            r_state    <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (ev_ready) begin
            r_last     <= r_ev_ch;
            r_ev_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_ev_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign ev_valid = r_ev_valid;
  assign ev_ch    = r_ev_ch;
  assign ev_count = r_ev_count;
  assign ovf      = r_ovf;

endmodule
